alu_logic_sequencer: RTL
========================

Name: alu_logic_sequencer

Overview:
Upstream and downstream wrapper for the 8-bit logic unit (AND/OR/NOT-concat/XOR, 16-bit result).
- Accepts operands X and Y as two beats on a shared 8-bit bus with valid/ready handshake. The op select is taken with the X beat.
- Holds X, Y and s stable on the lu_* outputs for a programmable settle time, to cover the unit's gate delays.
- Captures the 16-bit Z, derives flags and presents the result with valid/ready backpressure.

Parameters:
DATA_W, 8, operand width; the result is 2*DATA_W.
WAIT_CYCLES, 2, cycles that lu_* are held stable before lu_z is sampled. Legal range 1..15.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  sequencer can accept a beat
in_data  input  DATA_W  operand beat: X first, then Y
in_op  input  2  op select; sampled only on the X beat
lu_x  output  DATA_W  registered X to the logic unit
lu_y  output  DATA_W  registered Y to the logic unit
lu_s  output  2  registered op to the logic unit
lu_z  input  2*DATA_W  result from the logic unit
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_z  output  2*DATA_W  captured result
out_zero  output  1  out_z == 0
out_sign  output  1  out_z[2*DATA_W-1]

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - lu_x, lu_y, lu_s, out_z, out_zero, out_sign all 0.
  - out_valid=0.
  - in_ready=1 from the first cycle after reset.
- FSM states: IDLE, GET_Y, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: lu_x<=in_data, lu_s<=in_op, go to GET_Y.
- GET_Y:
  - in_ready=1. in_op is ignored.
  - On handshake: lu_y<=in_data, cnt<=WAIT_CYCLES-1, go to EXEC.
  - If in_valid is low, wait indefinitely.
- EXEC:
  - in_ready=0.
  - If cnt!=0: cnt decrements.
  - If cnt==0: out_z<=lu_z, flags computed from lu_z, out_valid<=1, go to DONE.
- Latency: Y accepted at edge N means out_valid is high after edge N+WAIT_CYCLES.
- DONE:
  - in_ready=0.
  - out_z and flags are held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE. The next X beat is accepted one cycle later at the earliest (no bypass).
- lu_x, lu_y and lu_s change only on their own capture handshakes. They remain stable through EXEC and DONE.
- Flags:
  - out_zero = (lu_z == 0), registered with out_z.
  - out_sign = lu_z MSB.
- Counter width: 4 bits. WAIT_CYCLES=1 means lu_z is sampled on the first EXEC edge.
- Reset mid-operation (any state): immediate return to IDLE. A partially loaded operand is discarded. out_valid drops after the reset edge, with no handshake required.
- in_valid asserted in EXEC or DONE is not accepted. in_ready=0 there; the upstream source must hold.
- X and Y values are not interpreted; any 8-bit pattern is legal.

Optional Feature:
Macro: ALU_SEQ_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit) = XOR-reduce of lu_z, registered with out_z and reset to 0.
  - Adds input in_par (1 bit), sampled with each beat.
  - A beat whose even parity mismatches in_par is still accepted. It sets a sticky output par_err (reset 0, cleared only by rst).
- Undefined:
  - None of these ports or registers exist.
  - Behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - typedef of the 2-bit op enum: OP_AND=2'b00, OP_OR=2'b01, OP_NOTCAT=2'b10, OP_XOR=2'b11.
  - typedef of the FSM state enum.
  - localparam DATA_W_DEF=8.
- One natural sub-module: alu_settle_counter, the loadable down-counter with a zero flag, reusable for other delay-gate stages.
- The logic unit is instantiated by the parent alongside this block, not inside it.

Test Plan:
- AND: op=00, X=0xF0, Y=0x3C, WAIT_CYCLES=2 → out_valid 2 cycles after the Y handshake; out_z=0x0030, zero=0, sign=0.
- OR with sign extend: op=01, X=0x80, Y=0x01 → out_z=0xFF81, sign=1, zero=0.
- NOT concat: op=10, X=0x0F, Y=0xF0 → out_z=0xF00F, sign=1. Also in_op changed to 11 during the Y beat → still op 10.
- XOR zero: op=11, X=0xAA, Y=0xAA → out_z=0x0000, zero=1. Hold out_ready=0 for 5 cycles → out_z, flags and out_valid stable; in_ready=0 throughout.
- Gap and back-to-back: 3 idle cycles between the X and Y beats → FSM waits in GET_Y. After out_ready, a new X is accepted on the next cycle (in_ready=1 in IDLE).
- Reset mid-EXEC: rst=1 for 1 cycle during EXEC → next cycle state IDLE, out_valid=0, lu_* all 0, in_ready=1. No stale result appears afterward.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the logic-unit sequencer: op encoding, FSM states and
// the settle-counter width.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    OP_AND    = 2'b00,
    OP_OR     = 2'b01,
    OP_NOTCAT = 2'b10,
    OP_XOR    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_Y,
    ST_EXEC,
    ST_DONE
  } state_e;

  // Counter preload so that lu_z is sampled on the wait_cycles-th EXEC edge.
  function automatic logic [CNT_W-1:0] settle_load(input int wait_cycles);
    return CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// Loadable down-counter with a zero flag; gates a stage until its
// combinational source has settled.
module alu_settle_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_logic_sequencer.sv
// Two-beat operand loader, settle-time holder and result register for the
// 8-bit logic unit. Optional parity checking under ALU_SEQ_PARITY_EN.
module alu_logic_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_op,
  output logic [DATA_W-1:0]   lu_x,
  output logic [DATA_W-1:0]   lu_y,
  output logic [1:0]          lu_s,
  input  logic [2*DATA_W-1:0] lu_z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_z,
  output logic                out_zero,
  output logic                out_sign
`ifdef ALU_SEQ_PARITY_EN
  ,
  input  logic                in_par,
  output logic                out_parity,
  output logic                par_err
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(WAIT_CYCLES);

  state_e              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   lu_x_q;
  logic [DATA_W-1:0]   lu_y_q;
  op_e                 lu_s_q;
  logic [2*DATA_W-1:0] out_z_q;
  logic                out_zero_q;
  logic                out_sign_q;

  logic beat_acc;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic capture;

  assign beat_acc = in_valid && in_ready_q;
  assign cnt_load = (state_q == ST_GET_Y) && beat_acc;
  assign cnt_dec  = (state_q == ST_EXEC);
  assign capture  = (state_q == ST_EXEC) && cnt_zero;

  alu_settle_counter #(
    .CNT_W (CNT_W)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      lu_x_q      <= '0;
      lu_y_q      <= '0;
      lu_s_q      <= OP_AND;
      out_z_q     <= '0;
      out_zero_q  <= 1'b0;
      out_sign_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat_acc) begin
            lu_x_q  <= in_data;
            lu_s_q  <= op_e'(in_op);
            state_q <= ST_GET_Y;
          end
        end
        ST_GET_Y: begin
          if (beat_acc) begin
            lu_y_q     <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_zero) begin
            out_z_q     <= lu_z;
            out_zero_q  <= (lu_z == '0);
            out_sign_q  <= lu_z[2*DATA_W-1];
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // in_ready rises with the IDLE entry, so a new X lands one cycle later.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PARITY_EN
  logic out_parity_q;
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity_q <= 1'b0;
      par_err_q    <= 1'b0;
    end else begin
      if (capture) begin
        out_parity_q <= ^lu_z;
      end
      // Mismatched beats are still accepted; the error is only recorded.
      if (beat_acc && ((^in_data) != in_par)) begin
        par_err_q <= 1'b1;
      end
    end
  end

  assign out_parity = out_parity_q;
  assign par_err    = par_err_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lu_x      = lu_x_q;
  assign lu_y      = lu_y_q;
  assign lu_s      = lu_s_q;
  assign out_z     = out_z_q;
  assign out_zero  = out_zero_q;
  assign out_sign  = out_sign_q;

endmodule
